// File: rtl/mips_cpu_ctrl_seq.sv
// Multi-cycle MIPS control sequencer: FETCH/EXEC/MEM/WB FSM with PC, branch delay slot
// tracking and a per-access waitrequest timeout that halts the core.
module mips_cpu_ctrl_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          WAIT_MAX     = 15,
    parameter int          WAIT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        waitrequest,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_is_branch,
    input  logic        dec_branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write_en,
    output logic        delay_slot,
    output logic        active,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d, tgt_q, tgt_d, pc_next;
    logic              pend_q, pend_d, dly_q, dly_d, terr_q, terr_d;
    logic              mrd_q, mrd_d, mwr_q, mwr_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;

    // The branch target is only taken once its delay slot has retired.
    assign pc_next = (pend_q && dly_q) ? tgt_q : pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;
        dly_d   = dly_q;
        terr_d  = terr_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wcnt_d  = '0;
            end
            S_FETCH, S_MEM: begin
                if (waitrequest) begin
                    if (wcnt_q == WAIT_W'(WAIT_MAX)) begin
                        state_d = S_HALT;
                        terr_d  = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    state_d = (state_q == S_FETCH) ? S_EXEC : S_WB;
                end
            end
            S_EXEC: begin
                // Branches inside a delay slot are dropped.
                if (dec_is_branch && dec_branch_taken && !dly_q) begin
                    tgt_d  = branch_target;
                    pend_d = 1'b1;
                end
                mrd_d = dec_mem_read;
                mwr_d = dec_mem_write;
                if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                    wcnt_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d   = pc_next;
                wcnt_d = '0;
                if (pend_q && dly_q) begin
                    pend_d = 1'b0;
                    dly_d  = 1'b0;
                end else if (pend_q) begin
                    dly_d = 1'b1;
                end
                state_d = (pc_next == 32'd0) ? S_HALT : S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            dly_q   <= 1'b0;
            terr_q  <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            wcnt_q  <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            dly_q   <= dly_d;
            terr_q  <= terr_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // MEM strobes come from values latched in EXEC so they cannot wobble during a stall.
    assign pc           = pc_q;
    assign state        = state_q;
    assign ir_write     = (state_q == S_FETCH) && !waitrequest;
    assign mem_read     = (state_q == S_FETCH) || ((state_q == S_MEM) && mrd_q);
    assign mem_write    = (state_q == S_MEM) && mwr_q;
    assign reg_write_en = (state_q == S_WB) && dec_reg_write;
    assign delay_slot   = dly_q;
    assign active       = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                          (state_q == S_MEM)   || (state_q == S_WB);
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mips_cpu_ctrl_seq.sv
// Directed bench for mips_cpu_ctrl_seq: instruction sequences with hand-computed expectations.
module tb_mips_cpu_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset, clk_enable, waitrequest;
    logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_is_branch, dec_branch_taken;
    logic [31:0] branch_target, pc;
    logic [2:0]  state;
    logic        ir_write, mem_read, mem_write, reg_write_en, delay_slot, active, timeout_err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mips_cpu_ctrl_seq dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .waitrequest(waitrequest),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_is_branch(dec_is_branch),
        .dec_branch_taken(dec_branch_taken), .branch_target(branch_target),
        .pc(pc), .state(state), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write_en(reg_write_en), .delay_slot(delay_slot),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_mem_read = 0; dec_mem_write = 0; dec_reg_write = 0;
        dec_is_branch = 0; dec_branch_taken = 0; branch_target = 32'h0;
    endtask

    task automatic run_alu();
        clear_dec(); waitrequest = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        reset = 0; clk_enable = 1; waitrequest = 0; clear_dec();
        tick();
        tot_cnt++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else pass_cnt++;
        tot_cnt++; if (pc !== 32'hBFC00000) $display("FAIL rst_pc got %h want bfc00000", pc); else pass_cnt++;
        tot_cnt++; if ({mem_read, mem_write, ir_write, active} !== 4'b0) $display("FAIL rst_strobes got %b want 0000", {mem_read, mem_write, ir_write, active}); else pass_cnt++;
        tot_cnt++; if ({timeout_err, delay_slot} !== 2'b0) $display("FAIL rst_flags got %b want 00", {timeout_err, delay_slot}); else pass_cnt++;
        reset = 1;
        tick();
        tot_cnt++; if (state !== 3'd1) $display("FAIL idle_to_fetch got %0d want 1", state); else pass_cnt++;
        tot_cnt++; if ({active, mem_read, ir_write} !== 3'b111) $display("FAIL fetch_outs got %b want 111", {active, mem_read, ir_write}); else pass_cnt++;
    endtask

    task automatic test_alu();
        clear_dec(); dec_reg_write = 1;
        tick();
        tot_cnt++; if (state !== 3'd2) $display("FAIL alu_exec got %0d want 2", state); else pass_cnt++;
        tot_cnt++; if ({mem_read, reg_write_en} !== 2'b00) $display("FAIL alu_exec_outs got %b want 00", {mem_read, reg_write_en}); else pass_cnt++;
        tick();
        tot_cnt++; if (state !== 3'd4 || reg_write_en !== 1'b1) $display("FAIL alu_wb got st=%0d rwe=%b want st=4 rwe=1", state, reg_write_en); else pass_cnt++;
        tot_cnt++; if (pc !== 32'hBFC00000) $display("FAIL alu_pc_hold got %h want bfc00000", pc); else pass_cnt++;
        tick();
        tot_cnt++; if (state !== 3'd1 || pc !== 32'hBFC00004) $display("FAIL alu_next got st=%0d pc=%h want st=1 pc=bfc00004", state, pc); else pass_cnt++;
        tot_cnt++; if (reg_write_en !== 1'b0) $display("FAIL alu_rwe_pulse got %b want 0", reg_write_en); else pass_cnt++;
    endtask

    task automatic test_load_wait();
        clear_dec(); dec_mem_read = 1; dec_reg_write = 1;
        tick();
        tot_cnt++; if (state !== 3'd2 || mem_read !== 1'b0) $display("FAIL ld_exec got st=%0d rd=%b want st=2 rd=0", state, mem_read); else pass_cnt++;
        tick();
        for (int i = 0; i < 4; i++) begin
            waitrequest = (i < 3);
            tot_cnt++; if (state !== 3'd3 || mem_read !== 1'b1 || mem_write !== 1'b0) $display("FAIL ld_mem_c%0d got st=%0d rd=%b wr=%b want st=3 rd=1 wr=0", i, state, mem_read, mem_write); else pass_cnt++;
            tot_cnt++; if (reg_write_en !== 1'b0) $display("FAIL ld_mem_rwe_c%0d got %b want 0", i, reg_write_en); else pass_cnt++;
            tick();
        end
        tot_cnt++; if (state !== 3'd4 || reg_write_en !== 1'b1 || mem_read !== 1'b0) $display("FAIL ld_wb got st=%0d rwe=%b rd=%b want st=4 rwe=1 rd=0", state, reg_write_en, mem_read); else pass_cnt++;
        tot_cnt++; if (timeout_err !== 1'b0) $display("FAIL ld_terr got %b want 0", timeout_err); else pass_cnt++;
        tick();
        tot_cnt++; if (pc !== 32'hBFC00008) $display("FAIL ld_pc got %h want bfc00008", pc); else pass_cnt++;
    endtask

    task automatic test_branch();
        run_alu(); run_alu();
        tot_cnt++; if (pc !== 32'hBFC00010) $display("FAIL br_setup_pc got %h want bfc00010", pc); else pass_cnt++;
        clear_dec(); dec_is_branch = 1; dec_branch_taken = 1; branch_target = 32'hBFC00100;
        tick(); tick();
        tot_cnt++; if (state !== 3'd4 || delay_slot !== 1'b0) $display("FAIL br_wb got st=%0d ds=%b want st=4 ds=0", state, delay_slot); else pass_cnt++;
        tick();
        tot_cnt++; if (pc !== 32'hBFC00014 || delay_slot !== 1'b1) $display("FAIL br_slot got pc=%h ds=%b want pc=bfc00014 ds=1", pc, delay_slot); else pass_cnt++;
        // taken branch inside the delay slot must be ignored
        branch_target = 32'hBFC00200;
        tick();
        tot_cnt++; if (delay_slot !== 1'b1) $display("FAIL br_slot_exec_ds got %b want 1", delay_slot); else pass_cnt++;
        tick(); tick();
        tot_cnt++; if (pc !== 32'hBFC00100 || delay_slot !== 1'b0 || state !== 3'd1) $display("FAIL br_target got pc=%h ds=%b st=%0d want pc=bfc00100 ds=0 st=1", pc, delay_slot, state); else pass_cnt++;
        clear_dec();
        run_alu();
        tot_cnt++; if (pc !== 32'hBFC00104) $display("FAIL br_after got %h want bfc00104", pc); else pass_cnt++;
    endtask

    task automatic test_clk_enable();
        waitrequest = 1; clk_enable = 0;
        for (int i = 0; i < 30; i++) tick();
        tot_cnt++; if (state !== 3'd1 || pc !== 32'hBFC00104 || timeout_err !== 1'b0) $display("FAIL ce_freeze got st=%0d pc=%h terr=%b want st=1 pc=bfc00104 terr=0", state, pc, timeout_err); else pass_cnt++;
        clk_enable = 1; waitrequest = 0;
        tick();
        tot_cnt++; if (state !== 3'd2) $display("FAIL ce_resume got %0d want 2", state); else pass_cnt++;
        tick(); tick();
        tot_cnt++; if (pc !== 32'hBFC00108) $display("FAIL ce_pc got %h want bfc00108", pc); else pass_cnt++;
    endtask

    task automatic test_jump_halt();
        clear_dec(); dec_is_branch = 1; dec_branch_taken = 1; branch_target = 32'h0;
        tick(); tick(); tick();
        tot_cnt++; if (state !== 3'd1 || delay_slot !== 1'b1 || pc !== 32'hBFC0010C) $display("FAIL jmp_slot got st=%0d ds=%b pc=%h want st=1 ds=1 pc=bfc0010c", state, delay_slot, pc); else pass_cnt++;
        clear_dec();
        tick(); tick(); tick();
        tot_cnt++; if (state !== 3'd5 || active !== 1'b0 || mem_read !== 1'b0) $display("FAIL jmp_halt got st=%0d act=%b rd=%b want st=5 act=0 rd=0", state, active, mem_read); else pass_cnt++;
        tick(); tick(); tick();
        tot_cnt++; if (state !== 3'd5 || mem_read !== 1'b0) $display("FAIL jmp_halt_stay got st=%0d rd=%b want st=5 rd=0", state, mem_read); else pass_cnt++;
    endtask

    task automatic test_timeout();
        reset = 0; #1;
        tot_cnt++; if (state !== 3'd0 || pc !== 32'hBFC00000) $display("FAIL to_rst got st=%0d pc=%h want st=0 pc=bfc00000", state, pc); else pass_cnt++;
        tick(); reset = 1;
        waitrequest = 1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        tot_cnt++; if (state !== 3'd1 || timeout_err !== 1'b0 || ir_write !== 1'b0) $display("FAIL to_15waits got st=%0d terr=%b ir=%b want st=1 terr=0 ir=0", state, timeout_err, ir_write); else pass_cnt++;
        tick();
        tot_cnt++; if (state !== 3'd5 || timeout_err !== 1'b1 || mem_read !== 1'b0) $display("FAIL to_halt got st=%0d terr=%b rd=%b want st=5 terr=1 rd=0", state, timeout_err, mem_read); else pass_cnt++;
        for (int i = 0; i < 4; i++) tick();
        waitrequest = 0;
        tick(); tick();
        tot_cnt++; if (state !== 3'd5 || timeout_err !== 1'b1 || active !== 1'b0) $display("FAIL to_sticky got st=%0d terr=%b act=%b want st=5 terr=1 act=0", state, timeout_err, active); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mem();
        reset = 0; #1;
        tot_cnt++; if (timeout_err !== 1'b0) $display("FAIL rm_terr_clr got %b want 0", timeout_err); else pass_cnt++;
        tick(); reset = 1;
        tick();
        clear_dec(); dec_mem_write = 1; dec_reg_write = 1; waitrequest = 0;
        tick();
        waitrequest = 1;
        tick();
        tot_cnt++; if (state !== 3'd3 || mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL rm_store got st=%0d wr=%b rd=%b want st=3 wr=1 rd=0", state, mem_write, mem_read); else pass_cnt++;
        #3 reset = 0;
        #1;
        tot_cnt++; if (mem_write !== 1'b0 || state !== 3'd0 || reg_write_en !== 1'b0) $display("FAIL rm_abort got wr=%b st=%0d rwe=%b want wr=0 st=0 rwe=0", mem_write, state, reg_write_en); else pass_cnt++;
        tot_cnt++; if (pc !== 32'hBFC00000) $display("FAIL rm_pc got %h want bfc00000", pc); else pass_cnt++;
        clear_dec(); waitrequest = 0;
        tick(); reset = 1;
        tot_cnt++; if (state !== 3'd0) $display("FAIL rm_idle got %0d want 0", state); else pass_cnt++;
        tick();
        tot_cnt++; if (state !== 3'd1 || pc !== 32'hBFC00000 || mem_read !== 1'b1) $display("FAIL rm_restart got st=%0d pc=%h rd=%b want st=1 pc=bfc00000 rd=1", state, pc, mem_read); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_clk_enable();
        test_jump_halt();
        test_timeout();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
